// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single regfile write port between the in-order writeback stage
// and late-completing producers such as the divider and uncached loads.
// Late results wait in a DEPTH-entry FIFO. The pipeline normally has priority.
// A head that waits too long forces a FORCE cycle, which stalls the pipeline.
// A granted pipeline write kills any older pending late write to the same rd.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pipe_valid/we/rd/data         writeback-stage write request
//   pipe_rdy                      writeback may retire this cycle
//   late_valid/rd/data, late_rdy  late-result offer and FIFO-accept handshake
//   reg_we/idx/data               regfile write port (combinational grant)
//   pend_mask                     registers with a live (unkilled) pending late write
//   fifo_cnt                      FIFO occupancy
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_valid,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_rd,
    input  logic [31:0]                pipe_data,
    output logic                       pipe_rdy,
    input  logic                       late_valid,
    input  logic [4:0]                 late_rd,
    input  logic [31:0]                late_data,
    output logic                       late_rdy,
    output logic                       reg_we,
    output logic [4:0]                 reg_idx,
    output logic [31:0]                reg_data,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_WAIT - 1);

    typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_t;

    state_t          state_r, state_n_s;
    logic [SW-1:0]   starve_r, starve_n_s;
    logic [4:0]      rd_r    [DEPTH];
    logic [31:0]     data_r  [DEPTH];
    logic [DEPTH-1:0] valid_r, kill_r;
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   cnt_r;

    logic pipe_req_s, head_ok_s, head_kill_s, empty_s;
    logic pipe_grant_s, head_grant_s, pop_s, enq_s, late_rdy_s, pipe_rdy_s;
    logic [31:0] pend_mask_s;

    assign pipe_req_s  = pipe_valid & pipe_we & (pipe_rd != 5'd0);
    assign empty_s     = (cnt_r == {CW{1'b0}});
    assign head_kill_s = kill_r[rd_ptr_r];
    assign head_ok_s   = ~empty_s & ~head_kill_s;
    assign late_rdy_s  = ~rst & (cnt_r < FULL_CNT);
    // r0 late results are acknowledged but never stored
    assign enq_s       = late_valid & late_rdy_s & (late_rd != 5'd0);
    // A killed head drains on its own without touching the write port
    assign pop_s       = ~rst & (head_grant_s | (~empty_s & head_kill_s));

    // Grant selection, FORCE sequencing and starvation counting
    always_comb begin
        pipe_grant_s = 1'b0;
        head_grant_s = 1'b0;
        pipe_rdy_s   = 1'b0;
        state_n_s    = ST_NORMAL;
        starve_n_s   = {SW{1'b0}};
        if (rst) begin
            state_n_s = ST_NORMAL;
        end else begin
            case (state_r)
                ST_NORMAL: begin
                    pipe_rdy_s = 1'b1;
                    if (pipe_req_s) begin
                        pipe_grant_s = 1'b1;
                    end else if (head_ok_s) begin
                        head_grant_s = 1'b1;
                    end else begin
                        pipe_grant_s = 1'b0;
                    end
                end
                ST_FORCE: begin
                    // Non-writing instructions may still retire during FORCE
                    pipe_rdy_s = ~pipe_req_s;
                    if (head_ok_s) begin
                        head_grant_s = 1'b1;
                    end else begin
                        head_grant_s = 1'b0;
                    end
                end
                default: begin
                    pipe_rdy_s = 1'b0;
                end
            endcase
            if (head_ok_s && !head_grant_s) begin
                if (starve_r == STARVE_LIM) begin
                    state_n_s  = ST_FORCE;
                    starve_n_s = starve_r;
                end else begin
                    starve_n_s = starve_r + SW'(1);
                end
            end else begin
                starve_n_s = {SW{1'b0}};
            end
        end
    end

    // Pending-rd mask from live FIFO entries
    always_comb begin
        pend_mask_s = 32'd0;
        if (rst) begin
            pend_mask_s = 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && !kill_r[i]) begin
                    pend_mask_s[rd_r[i]] = 1'b1;
                end else begin
                    pend_mask_s = pend_mask_s;
                end
            end
        end
    end

    assign reg_we    = pipe_grant_s | head_grant_s;
    assign reg_idx   = pipe_grant_s ? pipe_rd   : (head_grant_s ? rd_r[rd_ptr_r]   : 5'd0);
    assign reg_data  = pipe_grant_s ? pipe_data : (head_grant_s ? data_r[rd_ptr_r] : 32'd0);
    assign pipe_rdy  = pipe_rdy_s;
    assign late_rdy  = late_rdy_s;
    assign pend_mask = pend_mask_s;
    assign fifo_cnt  = rst ? {CW{1'b0}} : cnt_r;

    // FIFO storage, pointers, kill bits and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_NORMAL;
            starve_r <= {SW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            kill_r   <= {DEPTH{1'b0}};
        end else begin
            state_r  <= state_n_s;
            starve_r <= starve_n_s;
            // Younger pipeline write supersedes older pending late writes
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_grant_s && valid_r[i] && (rd_r[i] == pipe_rd)) begin
                    kill_r[i] <= 1'b1;
                end
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PW'(1);
            end
            if (enq_s) begin
                rd_r[wr_ptr_r]    <= late_rd;
                data_r[wr_ptr_r]  <= late_data;
                valid_r[wr_ptr_r] <= 1'b1;
                kill_r[wr_ptr_r]  <= pipe_grant_s && (late_rd == pipe_rd);
                wr_ptr_r          <= wr_ptr_r + PW'(1);
            end
            case ({enq_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_rdy;
    logic        late_valid;
    logic [4:0]  late_rd;
    logic [31:0] late_data;
    logic        late_rdy;
    logic        reg_we;
    logic [4:0]  reg_idx;
    logic [31:0] reg_data;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_cnt;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_rd(pipe_rd),
        .pipe_data(pipe_data), .pipe_rdy(pipe_rdy),
        .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data),
        .late_rdy(late_rdy),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
        .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs then settle #2 before checks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = v; pipe_we = v; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic late(input logic v, input logic [4:0] rd, input logic [31:0] d);
        late_valid = v; late_rd = rd; late_data = d;
    endtask

    initial begin
        rst = 1'b1;
        pipe(1'b1, 5'd6, 32'h66);
        late(1'b1, 5'd6, 32'h66);
        step(); step();
        #2;
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_pipe_rdy", {31'd0, pipe_rdy}, 32'd0);
        chk("rst_late_rdy", {31'd0, late_rdy}, 32'd0);
        chk("rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        step();
        rst = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        late(1'b0, 5'd0, 32'd0);
        #2;
        chk("idle_pipe_rdy", {31'd0, pipe_rdy}, 32'd1);
        chk("idle_cnt", {29'd0, fifo_cnt}, 32'd0);

        // late only, empty FIFO
        late(1'b1, 5'd5, 32'h11);
        #2;
        chk("t1_late_rdy", {31'd0, late_rdy}, 32'd1);
        chk("t1_no_we", {31'd0, reg_we}, 32'd0);
        step();
        late(1'b0, 5'd0, 32'd0);
        #2;
        chk("t1_we", {31'd0, reg_we}, 32'd1);
        chk("t1_idx", {27'd0, reg_idx}, 32'd5);
        chk("t1_data", reg_data, 32'h11);
        chk("t1_pend", pend_mask, 32'h0000_0020);
        chk("t1_cnt", {29'd0, fifo_cnt}, 32'd1);
        step();
        #2;
        chk("t1_pend_clr", pend_mask, 32'd0);
        chk("t1_we_clr", {31'd0, reg_we}, 32'd0);
        chk("t1_cnt_clr", {29'd0, fifo_cnt}, 32'd0);

        // contention: pipe writes r3 every cycle, one late r7
        pipe(1'b1, 5'd3, 32'h33);
        late(1'b1, 5'd7, 32'h77);
        #2;
        chk("t2_c0_idx", {27'd0, reg_idx}, 32'd3);
        step();
        late(1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("t2_pipe_idx", {27'd0, reg_idx}, 32'd3);
            chk("t2_pipe_rdy", {31'd0, pipe_rdy}, 32'd1);
            chk("t2_pend", pend_mask, 32'h0000_0080);
            step();
        end
        #2;
        chk("t2_force_rdy", {31'd0, pipe_rdy}, 32'd0);
        chk("t2_force_we", {31'd0, reg_we}, 32'd1);
        chk("t2_force_idx", {27'd0, reg_idx}, 32'd7);
        chk("t2_force_data", reg_data, 32'h77);
        step();
        #2;
        chk("t2_after_rdy", {31'd0, pipe_rdy}, 32'd1);
        chk("t2_after_idx", {27'd0, reg_idx}, 32'd3);
        chk("t2_after_cnt", {29'd0, fifo_cnt}, 32'd0);

        // kill: late r9=0xA pending, pipe writes r9=0xB
        pipe(1'b1, 5'd1, 32'h1);
        late(1'b1, 5'd9, 32'hA);
        step();
        late(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd9, 32'hB);
        #2;
        chk("t3_idx", {27'd0, reg_idx}, 32'd9);
        chk("t3_data", reg_data, 32'hB);
        chk("t3_pend_live", pend_mask, 32'h0000_0200);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        #2;
        chk("t3_pop_no_we", {31'd0, reg_we}, 32'd0);
        chk("t3_pend_killed", pend_mask, 32'd0);
        chk("t3_cnt_killed", {29'd0, fifo_cnt}, 32'd1);
        step();
        #2;
        chk("t3_cnt_drained", {29'd0, fifo_cnt}, 32'd0);
        chk("t3_no_we", {31'd0, reg_we}, 32'd0);

        // full: four enqueues while the pipe is busy, fifth held
        pipe(1'b1, 5'd2, 32'h22);
        for (int k = 0; k < 4; k++) begin
            late(1'b1, 5'(10 + k), 32'h100 + 32'(10 + k));
            #2;
            chk("t4_fill_rdy", {31'd0, late_rdy}, 32'd1);
            step();
        end
        late(1'b1, 5'd14, 32'h10E);
        #2;
        chk("t4_full_rdy", {31'd0, late_rdy}, 32'd0);
        chk("t4_full_cnt", {29'd0, fifo_cnt}, 32'd4);
        chk("t4_full_pend", pend_mask, 32'h0000_3C00);
        chk("t4_pipe_idx", {27'd0, reg_idx}, 32'd2);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        #2;
        chk("t4_pop_idx", {27'd0, reg_idx}, 32'd10);
        chk("t4_pop_rdy", {31'd0, late_rdy}, 32'd0);
        step();
        #2;
        chk("t4_cnt3", {29'd0, fifo_cnt}, 32'd3);
        chk("t4_rdy_again", {31'd0, late_rdy}, 32'd1);
        chk("t4_idx11", {27'd0, reg_idx}, 32'd11);
        step();
        late(1'b0, 5'd0, 32'd0);
        #2;
        chk("t4_cnt_same", {29'd0, fifo_cnt}, 32'd3);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t4_drain_idx", {27'd0, reg_idx}, 32'(12 + k));
            chk("t4_drain_data", reg_data, 32'h100 + 32'(12 + k));
            step();
        end
        #2;
        chk("t4_empty", {29'd0, fifo_cnt}, 32'd0);

        // r0: neither source may write or store
        pipe(1'b1, 5'd0, 32'hDEAD);
        late(1'b1, 5'd0, 32'hBEEF);
        #2;
        chk("t5_no_we", {31'd0, reg_we}, 32'd0);
        chk("t5_pipe_rdy", {31'd0, pipe_rdy}, 32'd1);
        chk("t5_late_rdy", {31'd0, late_rdy}, 32'd1);
        step();
        #2;
        chk("t5_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("t5_no_we2", {31'd0, reg_we}, 32'd0);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        late(1'b0, 5'd0, 32'd0);
        #2;
        chk("t5_no_we3", {31'd0, reg_we}, 32'd0);

        // reset with three entries pending
        pipe(1'b1, 5'd4, 32'h44);
        for (int k = 0; k < 3; k++) begin
            late(1'b1, 5'(20 + k), 32'h200 + 32'(k));
            step();
        end
        late(1'b0, 5'd0, 32'd0);
        #2;
        chk("t6_cnt3", {29'd0, fifo_cnt}, 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_we", {31'd0, reg_we}, 32'd0);
        chk("t6_rst_pipe_rdy", {31'd0, pipe_rdy}, 32'd0);
        step();
        rst = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        #2;
        chk("t6_cnt0", {29'd0, fifo_cnt}, 32'd0);
        chk("t6_pend0", pend_mask, 32'd0);
        chk("t6_we0", {31'd0, reg_we}, 32'd0);
        step();
        #2;
        chk("t6_we0_later", {31'd0, reg_we}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
